wave_profile_ctrl: RTL and testbench

Sequencer and buffer arbiter for wave-profile generation. Accepts frequency updates, drives the frequency-divider/sine-ROM lookup path one horizontal index per cycle, and writes results into the back half of a ping-pong profile RAM. It swaps the front/back banks only on a frame boundary (`vsync`), so the renderer never reads a half-written profile. It sits between the frequency source and the display renderer.

---
 rtl/wave_pkg.sv | 15 +
 rtl/wave_req_slot.sv | 35 +++
 rtl/wave_profile_ctrl.sv | 124 ++++++++++++
 tb/tb_wave_profile_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// Shared types and default sizing for the wave-profile generation path.
package wave_pkg;

  localparam int WAVE_LOG_WIDTH = 10;
  localparam int WAVE_WIDTH     = 1024;
  localparam int WAVE_RESOL     = 10;
  localparam int WAVE_FREQ_W    = 11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CALC      = 2'd1,
    WAIT_SWAP = 2'd2
  } wave_ctrl_state_t;

endpackage

// File: rtl/wave_req_slot.sv
// One-deep pending frequency request: latest load wins, consume clears,
// and a load onto an unconsumed request raises a one-cycle overrun pulse.
module wave_req_slot
  import wave_pkg::*;
#(
  parameter int FREQ_W = WAVE_FREQ_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [FREQ_W-1:0] load_freq,
  input  logic              consume,
  output logic              pend_valid,
  output logic [FREQ_W-1:0] pend_freq,
  output logic              overrun
);

  // Consumption is evaluated first, so a same-cycle load simply refills the slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_freq  <= '0;
      overrun    <= 1'b0;
    end else begin
      overrun <= load && pend_valid && !consume;
      if (load) begin
        pend_valid <= 1'b1;
        pend_freq  <= load_freq;
      end else if (consume) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/wave_profile_ctrl.sv
// Wave-profile sequencer and ping-pong bank arbiter; banks swap only on vsync.
// Optional WAVE_CTRL_ABORT_EN: a new request during CALC/WAIT_SWAP restarts the profile.
module wave_profile_ctrl
  import wave_pkg::*;
#(
  parameter int LOG_WIDTH = WAVE_LOG_WIDTH,
  parameter int WIDTH     = WAVE_WIDTH,
  parameter int RESOL     = WAVE_RESOL
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WAVE_FREQ_W-1:0] frequency,
  input  logic                   new_f,
  input  logic                   vsync,
  output logic [LOG_WIDTH-1:0]   rom_out_index,
  output logic [WAVE_FREQ_W-1:0] rom_freq,
  input  logic [RESOL-1:0]       rom_value,
  output logic                   wr_en,
  output logic                   wr_bank,
  output logic [LOG_WIDTH-1:0]   wr_addr,
  output logic [RESOL-1:0]       wr_data,
  output logic                   rd_bank,
  output logic                   busy,
  output logic                   wave_ready,
  output logic                   overrun
);

  localparam logic [LOG_WIDTH-1:0] LAST_ADDR = LOG_WIDTH'(WIDTH - 1);

  wave_ctrl_state_t        state, state_next;
  logic [LOG_WIDTH-1:0]    addr, addr_next;
  logic [WAVE_FREQ_W-1:0]  freq_next;
  logic                    consume, swap, calc_write;
  logic                    slot_load, pend_valid;
  logic [WAVE_FREQ_W-1:0]  pend_freq;

`ifdef WAVE_CTRL_ABORT_EN
  assign slot_load = new_f && (state == IDLE);
`else
  assign slot_load = new_f;
`endif

  wave_req_slot #(.FREQ_W(WAVE_FREQ_W)) u_slot (
    .clock      (clock),
    .reset      (reset),
    .load       (slot_load),
    .load_freq  (frequency),
    .consume    (consume),
    .pend_valid (pend_valid),
    .pend_freq  (pend_freq),
    .overrun    (overrun)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // The address stops at the last entry rather than wrapping; WAIT_SWAP holds it.
  always_comb begin
    state_next = state;
    addr_next  = addr;
    freq_next  = rom_freq;
    consume    = 1'b0;
    swap       = 1'b0;
    calc_write = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend_valid) begin
          consume    = 1'b1;
          freq_next  = pend_freq;
          addr_next  = '0;
          state_next = CALC;
        end
      end
      CALC: begin
        calc_write = 1'b1;
        if (addr == LAST_ADDR) state_next = WAIT_SWAP;
        else                   addr_next  = LOG_WIDTH'(addr + 1'b1);
      end
      WAIT_SWAP: begin
        if (vsync) begin
          swap       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
`ifdef WAVE_CTRL_ABORT_EN
    // A restart wins over a coincident vsync; the discarded profile never goes live.
    if (new_f && (state != IDLE)) begin
      swap       = 1'b0;
      addr_next  = '0;
      freq_next  = frequency;
      state_next = CALC;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr       <= '0;
      rom_freq   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      rd_bank    <= 1'b0;
      wave_ready <= 1'b0;
    end else begin
      addr       <= addr_next;
      rom_freq   <= freq_next;
      wr_en      <= calc_write;
      wr_addr    <= calc_write ? addr : '0;
      wr_data    <= (calc_write && (addr != '0)) ? rom_value : '0;
      rd_bank    <= rd_bank ^ swap;
      wave_ready <= swap;
    end
  end

  assign wr_bank       = ~rd_bank;
  assign busy          = (state != IDLE);
  assign rom_out_index = (state == CALC) ? addr : '0;

endmodule

// File: tb/tb_wave_profile_ctrl.sv
// Directed bench for wave_profile_ctrl at WIDTH=16; honours WAVE_CTRL_ABORT_EN.
module tb_wave_profile_ctrl;
  import wave_pkg::*;

  localparam int LW = 4;
  localparam int W  = 16;
  localparam int RS = 10;

  logic          clock = 1'b0;
  logic          reset, new_f, vsync;
  logic [10:0]   frequency, rom_freq;
  logic [LW-1:0] rom_out_index, wr_addr;
  logic [RS-1:0] rom_value, wr_data;
  logic          wr_en, wr_bank, rd_bank, busy, wave_ready, overrun;

  int tests = 0;
  int fails = 0;
  int ovr_cnt = 0;
  int ready_cnt = 0;
  logic [RS-1:0] ram [2][W];

  typedef struct {
    logic        rst;
    logic        nf;
    logic        vs;
    logic [10:0] f;
    int          reps;
    logic        e_busy;
    logic        e_rd_bank;
    logic        e_wr_en;
    logic        e_ready;
    logic [10:0] e_rom_freq;
  } vec_t;

  vec_t vecs[6];

  always #5 clock = ~clock;

  wave_profile_ctrl #(.LOG_WIDTH(LW), .WIDTH(W), .RESOL(RS)) dut (
    .clock         (clock),
    .reset         (reset),
    .frequency     (frequency),
    .new_f         (new_f),
    .vsync         (vsync),
    .rom_out_index (rom_out_index),
    .rom_freq      (rom_freq),
    .rom_value     (rom_value),
    .wr_en         (wr_en),
    .wr_bank       (wr_bank),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_bank       (rd_bank),
    .busy          (busy),
    .wave_ready    (wave_ready),
    .overrun       (overrun)
  );

  function automatic logic [RS-1:0] model_rom(input logic [10:0] f, input int k);
    int v;
    v = (int'(f) * (k + 3)) ^ (k << 5);
    return RS'(v);
  endfunction

  function automatic int expected_entry(input logic [10:0] f, input int k);
    return (k == 0) ? 0 : int'(model_rom(f, k));
  endfunction

  assign rom_value = model_rom(rom_freq, int'(rom_out_index));

  // Profile RAM and pulse counters, sampled mid-cycle.
  always @(negedge clock) begin
    if (overrun)    ovr_cnt++;
    if (wave_ready) ready_cnt++;
    if (wr_en)      ram[wr_bank][wr_addr] = wr_data;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic nf, input logic [10:0] f, input logic vs);
    new_f = nf;
    frequency = f;
    vsync = vs;
    tick();
    new_f = 1'b0;
    vsync = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkWrites(input logic [10:0] f, input logic bank);
    for (int k = 0; k < W; k++) begin
      tick();
      checkOutput("wr_en", int'(wr_en), 1);
      checkOutput("wr_addr", int'(wr_addr), k);
      checkOutput("wr_bank", int'(wr_bank), int'(bank));
      checkOutput("wr_data", int'(wr_data), expected_entry(f, k));
    end
  endtask

  task automatic startRun(input logic [10:0] f);
    applyStimulus(1'b1, f, 1'b0);
    checkOutput("busy_after_strobe", int'(busy), 0);
    tick();
    checkOutput("busy_rise", int'(busy), 1);
    checkOutput("rom_freq_latched", int'(rom_freq), int'(f));
    checkOutput("wr_en_latency", int'(wr_en), 0);
  endtask

  task automatic doSwap(input logic exp_rd);
    applyStimulus(1'b0, 11'd0, 1'b1);
    checkOutput("wave_ready_pulse", int'(wave_ready), 1);
    checkOutput("rd_bank_swap", int'(rd_bank), int'(exp_rd));
    checkOutput("busy_fall", int'(busy), 0);
    tick();
    checkOutput("wave_ready_single", int'(wave_ready), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int reached;
    int ovr_base;
    int ready_base;
    logic [10:0] final_freq;

    reset = 1'b1;
    new_f = 1'b0;
    vsync = 1'b0;
    frequency = '0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 11'd0,   2,  1'b0, 1'b0, 1'b0, 1'b0, 11'd0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 11'd0,   20, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 11'd0,   1,  1'b0, 1'b0, 1'b0, 1'b0, 11'd0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 11'd0,   2,  1'b0, 1'b0, 1'b0, 1'b0, 11'd0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 11'd440, 1,  1'b0, 1'b0, 1'b0, 1'b0, 11'd0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 11'd0,   1,  1'b1, 1'b0, 1'b0, 1'b0, 11'd440};

    // Reset, idle (vsync ignored), then a 440 request up to the first CALC cycle.
    for (int i = 0; i < 6; i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        reset = vecs[i].rst;
        applyStimulus(vecs[i].nf, vecs[i].f, vecs[i].vs);
        checkOutput("busy", int'(busy), int'(vecs[i].e_busy));
        checkOutput("rd_bank", int'(rd_bank), int'(vecs[i].e_rd_bank));
        checkOutput("wr_bank", int'(wr_bank), int'(!vecs[i].e_rd_bank));
        checkOutput("wr_en", int'(wr_en), int'(vecs[i].e_wr_en));
        checkOutput("wave_ready", int'(wave_ready), int'(vecs[i].e_ready));
        checkOutput("rom_freq", int'(rom_freq), int'(vecs[i].e_rom_freq));
        checkOutput("rom_out_index", int'(rom_out_index), 0);
        checkOutput("overrun", int'(overrun), 0);
      end
    end
    reset = 1'b0;

    checkWrites(11'd440, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("holdoff_wr_en", int'(wr_en), 0);
      checkOutput("holdoff_ready", int'(wave_ready), 0);
      checkOutput("holdoff_busy", int'(busy), 1);
    end
    doSwap(1'b1);

    startRun(11'd200);
    checkWrites(11'd200, 1'b0);
    doSwap(1'b0);

    // Two strobes during CALC of a 100 profile going into bank 1.
    ovr_base = ovr_cnt;
    applyStimulus(1'b1, 11'd100, 1'b0);
    tick();
    repeat (5) tick();
    applyStimulus(1'b1, 11'd300, 1'b0);
`ifdef WAVE_CTRL_ABORT_EN
    checkOutput("abort1_index", int'(rom_out_index), 0);
    checkOutput("abort1_freq", int'(rom_freq), 300);
    checkOutput("abort1_inflight", int'(wr_addr), 5);
`else
    checkOutput("queue1_index", int'(rom_out_index), 6);
    checkOutput("queue1_freq", int'(rom_freq), 100);
`endif
    repeat (3) tick();
    applyStimulus(1'b1, 11'd500, 1'b0);
`ifdef WAVE_CTRL_ABORT_EN
    checkOutput("abort2_index", int'(rom_out_index), 0);
    checkOutput("abort2_freq", int'(rom_freq), 500);
    tick();
    checkOutput("abort2_restart_addr", int'(wr_addr), 0);
    final_freq = 11'd500;
`else
    checkOutput("queue2_freq", int'(rom_freq), 100);
    final_freq = 11'd100;
`endif
    reached = 0;
    for (int i = 0; i < 40 && reached == 0; i++) begin
      if (wr_en && int'(wr_addr) == W - 1) reached = 1;
      else tick();
    end
    checkOutput("wait_last_write", reached, 1);
    tick();
    for (int k = 0; k < W; k++)
      checkOutput("bank1_entry", int'(ram[1][k]), expected_entry(final_freq, k));
`ifdef WAVE_CTRL_ABORT_EN
    checkOutput("overrun_count", ovr_cnt - ovr_base, 0);
    doSwap(1'b1);
    startRun(11'd200);
    checkWrites(11'd200, 1'b0);
    doSwap(1'b0);
`else
    checkOutput("overrun_count", ovr_cnt - ovr_base, 1);
    doSwap(1'b1);
    checkOutput("queued_busy", int'(busy), 1);
    checkOutput("queued_freq", int'(rom_freq), 500);
    checkWrites(11'd500, 1'b0);
    doSwap(1'b0);
    repeat (3) tick();
    checkOutput("slot_drained_busy", int'(busy), 0);
`endif

    // Reset while the lookup sits at addr 7.
    ready_base = ready_cnt;
    startRun(11'd50);
    repeat (7) tick();
    checkOutput("pre_reset_index", int'(rom_out_index), 7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("reset_wr_en", int'(wr_en), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_rd_bank", int'(rd_bank), 0);
    repeat (3) tick();
    applyStimulus(1'b0, 11'd0, 1'b1);
    tick();
    checkOutput("reset_no_swap", int'(rd_bank), 0);
    checkOutput("reset_no_ready", ready_cnt - ready_base, 0);
    checkOutput("reset_idle_wr_en", int'(wr_en), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
